// File: rtl/matrix_bram_loader_pkg.sv
// matrix_bram_loader_pkg: loader FSM state encoding and the default widths
// shared with the matmul wrapper.
package matrix_bram_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_DWIDTH            = 8;
  localparam int DEF_MAT_MUL_SIZE      = 8;
  localparam int DEF_AWIDTH            = 11;
  localparam int DEF_ADDR_STRIDE_WIDTH = 8;
  localparam int DEF_CNT_WIDTH         = $clog2(DEF_MAT_MUL_SIZE) + 1;

endpackage

// File: rtl/matrix_bram_loader_row_packer.sv
// matrix_bram_loader_row_packer: collects one row of stream elements into
// lanes and produces the RAM word plus lane write enables.
// Build option LOADER_ZERO_PAD_EN: lanes >= num_cols are forced to zero and
// every lane is written; otherwise only lanes < num_cols are written.
module matrix_bram_loader_row_packer
  import matrix_bram_loader_pkg::*;
#(
  parameter int DWIDTH       = DEF_DWIDTH,
  parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           clear_i,
  input  logic                           push_i,
  input  logic [DWIDTH-1:0]              data_i,
  input  logic [CNT_WIDTH-1:0]           num_cols_i,
  output logic                           last_o,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] wdata_o,
  output logic [MAT_MUL_SIZE-1:0]        we_o
);

  logic [CNT_WIDTH-1:0]                    col_q, col_d;
  logic [MAT_MUL_SIZE-1:0][DWIDTH-1:0]     lanes_q, lanes_d, lanes_out;
  logic [MAT_MUL_SIZE-1:0]                 in_row;

  // The element accepted at col num_cols-1 completes the row.
  assign last_o = push_i && (col_q == num_cols_i - 1'b1);

  // Column pointer: restarts on a new load or after each row write.
  always_comb begin
    col_d = col_q;
    if (clear_i)     col_d = '0;
    else if (push_i) col_d = col_q + 1'b1;
  end

  // Per-lane insert and write-enable / pad logic. The word output carries the
  // element being accepted this cycle so the last beat lands in the row word.
  for (genvar i = 0; i < MAT_MUL_SIZE; i++) begin : g_lane
    assign lanes_d[i] = (push_i && (col_q == CNT_WIDTH'(i))) ? data_i : lanes_q[i];
    assign in_row[i]  = (CNT_WIDTH'(i) < num_cols_i);
`ifdef LOADER_ZERO_PAD_EN
    assign lanes_out[i] = in_row[i] ? lanes_d[i] : '0;
    assign we_o[i]      = 1'b1;
`else
    assign lanes_out[i] = lanes_d[i];
    assign we_o[i]      = in_row[i];
`endif
  end

  assign wdata_o = lanes_out;

  // Lane and column registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q   <= '0;
      lanes_q <= '0;
    end else begin
      col_q   <= col_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/matrix_bram_loader.sv
// matrix_bram_loader: streams one matrix (row-major, one element per beat)
// into a RAM external port, one packed row per word at base + row*stride.
// Build option LOADER_ZERO_PAD_EN (see row_packer) zero-pads partial rows.
module matrix_bram_loader
  import matrix_bram_loader_pkg::*;
#(
  parameter int DWIDTH            = DEF_DWIDTH,
  parameter int MAT_MUL_SIZE      = DEF_MAT_MUL_SIZE,
  parameter int AWIDTH            = DEF_AWIDTH,
  parameter int ADDR_STRIDE_WIDTH = DEF_ADDR_STRIDE_WIDTH,
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           load_start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [ADDR_STRIDE_WIDTH-1:0]   stride,
  input  logic [CNT_WIDTH-1:0]           num_rows,
  input  logic [CNT_WIDTH-1:0]           num_cols,
  input  logic                           s_valid,
  input  logic [DWIDTH-1:0]              s_data,
  output logic                           s_ready,
  output logic [AWIDTH-1:0]              bram_addr_ext,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata_ext,
  output logic [MAT_MUL_SIZE-1:0]        bram_we_ext,
  output logic                           busy,
  output logic                           done,
  input  logic                           clear_done
);

  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAT_MUL_SIZE);

  state_e                         state_q;
  logic                           s_ready_q, busy_q, done_q;
  logic [MAT_MUL_SIZE-1:0]        we_q;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] wdata_q;
  logic [AWIDTH-1:0]              addr_q;
  logic [ADDR_STRIDE_WIDTH-1:0]   stride_q;
  logic [CNT_WIDTH-1:0]           rows_q, cols_q, row_q;

  logic [CNT_WIDTH-1:0]           rows_clamp, cols_clamp;
  logic                           start_go, accept, row_last, pk_clear;
  logic [MAT_MUL_SIZE*DWIDTH-1:0] pk_wdata;
  logic [MAT_MUL_SIZE-1:0]        pk_we;

  assign rows_clamp = (num_rows > MAX_CNT) ? MAX_CNT : num_rows;
  assign cols_clamp = (num_cols > MAX_CNT) ? MAX_CNT : num_cols;
  assign start_go   = load_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign accept     = s_valid && s_ready_q;
  assign pk_clear   = start_go || (state_q == ST_WRITE);

  matrix_bram_loader_row_packer #(
    .DWIDTH       (DWIDTH),
    .MAT_MUL_SIZE (MAT_MUL_SIZE),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .clear_i    (pk_clear),
    .push_i     (accept),
    .data_i     (s_data),
    .num_cols_i (cols_q),
    .last_o     (row_last),
    .wdata_o    (pk_wdata),
    .we_o       (pk_we)
  );

  // Load FSM with registered handshake, status and RAM port outputs.
  // addr_q is the current row address; it advances by stride after each write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      stride_q  <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_go) begin
            addr_q   <= base_addr;
            stride_q <= stride;
            rows_q   <= rows_clamp;
            cols_q   <= cols_clamp;
            row_q    <= '0;
            if ((rows_clamp == '0) || (cols_clamp == '0)) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_FILL;
              s_ready_q <= 1'b1;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
            end
          end else if ((state_q == ST_DONE) && clear_done) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
          end
        end
        ST_FILL: begin
          if (row_last) begin
            state_q   <= ST_WRITE;
            s_ready_q <= 1'b0;
            we_q      <= pk_we;
            wdata_q   <= pk_wdata;
          end
        end
        ST_WRITE: begin
          we_q   <= '0;
          addr_q <= addr_q + AWIDTH'(stride_q);
          row_q  <= row_q + 1'b1;
          if (row_q == rows_q - 1'b1) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= ST_FILL;
            s_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready        = s_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign bram_we_ext    = we_q;
  assign bram_wdata_ext = wdata_q;
  assign bram_addr_ext  = addr_q;

endmodule
